tqvp_pwm_multi: RTL and testbench

//  Multi-channel PWM byte peripheral on the TinyQV byte bus. Shared prescaled timebase

---
 rtl/tqvp_pwm_pkg.sv | 19 +
 rtl/tqvp_pwm_channel.sv | 34 +++
 rtl/tqvp_pwm_multi.sv | 164 ++++++++++++++++
 tb/tb_tqvp_pwm_multi.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tqvp_pwm_pkg.sv
// Shared register map and CTRL field positions for the multi-channel PWM peripheral.
package tqvp_pwm_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_TOP    = 4'h1;
  localparam logic [3:0] ADDR_POL    = 4'h2;
  localparam logic [3:0] ADDR_STATUS = 4'h3;
  localparam logic [3:0] ADDR_DUTY0  = 4'h4;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_MODE_BIT  = 1;
  localparam int CTRL_PRESC_LSB = 4;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/tqvp_pwm_channel.sv
// One PWM channel: active duty register, compare against the shared counter,
// polarity and the registered output.
module tqvp_pwm_channel (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       load_i,
  input  logic [7:0] duty_sh_i,
  input  logic [7:0] cnt_i,
  input  logic       pol_i,
  output logic       pwm_o
);

  logic [7:0] duty_act_q, duty_act_d;
  logic       pwm_q, pwm_d;

  always_comb begin
    duty_act_d = load_i ? duty_sh_i : duty_act_q;
    pwm_d      = en_i ? ((cnt_i < duty_act_q) ^ pol_i) : pol_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_act_q <= 8'h00;
      pwm_q      <= 1'b0;
    end else begin
      duty_act_q <= duty_act_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/tqvp_pwm_multi.sv
// Multi-channel PWM byte peripheral: bus decode, prescaler, shared up/up-down
// counter with double-buffered TOP, sticky WRAP status and per-channel outputs.
module tqvp_pwm_multi #(
  parameter int NUM_CH  = 4,
  parameter int PRESC_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);
  import tqvp_pwm_pkg::*;

  // state    | meaning
  // DIR_UP   | counting up (edge mode always stays here)
  // DIR_DOWN | centre mode, counting down towards 0

  logic               ctrl_en_q, ctrl_mode_q;
  logic [PRESC_W-1:0] presc_q;
  logic [7:0]         top_sh_q, top_act_q;
  logic [NUM_CH-1:0]  pol_q;
  logic               wrap_q;
  logic [7:0]         duty_sh_q [NUM_CH];

  dir_e               state_q, state_d, state_step;
  logic [7:0]         cnt_q, cnt_d, cnt_step;
  logic [PRESC_W-1:0] psc_q, psc_d;
  logic               tick, boundary, load, mode_chg;
  logic [NUM_CH-1:0]  pwm;
  logic               unused_ok;

  assign unused_ok = ^{ui_in, data_in};
  assign mode_chg  = data_write && (address == ADDR_CTRL) &&
                     (data_in[CTRL_MODE_BIT] != ctrl_mode_q);
  assign load      = boundary || !ctrl_en_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DIR_UP;
      cnt_q   <= 8'h00;
      psc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      psc_q   <= psc_d;
    end
  end

  always_comb begin
    cnt_step   = cnt_q;
    state_step = state_q;
    if (!ctrl_mode_q) begin
      cnt_step   = (cnt_q >= top_act_q) ? 8'h00 : cnt_q + 8'd1;
      state_step = DIR_UP;
    end else if (state_q == DIR_UP) begin
      if (cnt_q < top_act_q) begin
        cnt_step = cnt_q + 8'd1;
      end else if (top_act_q <= 8'd1) begin
        cnt_step = 8'h00;
      end else begin
        cnt_step   = top_act_q - 8'd1;
        state_step = DIR_DOWN;
      end
    end else if (cnt_q <= 8'd1) begin
      cnt_step   = 8'h00;
      state_step = DIR_UP;
    end else begin
      cnt_step = cnt_q - 8'd1;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    psc_d   = '0;
    if (!ctrl_en_q) begin
      state_d = DIR_UP;
      cnt_d   = 8'h00;
    end else begin
      psc_d = tick ? '0 : psc_q + 1'b1;
      if (mode_chg) begin
        state_d = DIR_UP;
        cnt_d   = 8'h00;
      end else if (tick) begin
        state_d = state_step;
        cnt_d   = cnt_step;
      end
    end
  end

  // A boundary is any tick whose next count is 0; TOP=0 makes every tick one.
  always_comb begin
    tick     = ctrl_en_q && (psc_q == presc_q);
    boundary = tick && (cnt_step == 8'h00);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_en_q   <= 1'b0;
      ctrl_mode_q <= 1'b0;
      presc_q     <= '0;
      top_sh_q    <= 8'hFF;
      top_act_q   <= 8'hFF;
      pol_q       <= '0;
      wrap_q      <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) duty_sh_q[ch] <= 8'h00;
    end else begin
      if (load) top_act_q <= top_sh_q;
      if (boundary) wrap_q <= 1'b1;
      else if (data_write && (address == ADDR_STATUS) && data_in[0]) wrap_q <= 1'b0;
      if (data_write) begin
        case (address)
          ADDR_CTRL: begin
            ctrl_en_q   <= data_in[CTRL_EN_BIT];
            ctrl_mode_q <= data_in[CTRL_MODE_BIT];
            presc_q     <= data_in[CTRL_PRESC_LSB +: PRESC_W];
          end
          ADDR_TOP: top_sh_q <= data_in;
          ADDR_POL: pol_q    <= data_in[NUM_CH-1:0];
          default: begin
            for (int ch = 0; ch < NUM_CH; ch++)
              if (address == 4'(ADDR_DUTY0 + ch)) duty_sh_q[ch] <= data_in;
          end
        endcase
      end
    end
  end

  always_comb begin
    data_out = 8'h00;
    case (address)
      ADDR_CTRL: begin
        data_out[CTRL_EN_BIT]                  = ctrl_en_q;
        data_out[CTRL_MODE_BIT]                = ctrl_mode_q;
        data_out[CTRL_PRESC_LSB +: PRESC_W]    = presc_q;
      end
      ADDR_TOP:    data_out = top_sh_q;
      ADDR_POL:    data_out[NUM_CH-1:0] = pol_q;
      ADDR_STATUS: data_out[0] = wrap_q;
      default: begin
        for (int ch = 0; ch < NUM_CH; ch++)
          if (address == 4'(ADDR_DUTY0 + ch)) data_out = duty_sh_q[ch];
      end
    endcase
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    tqvp_pwm_channel u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (ctrl_en_q),
      .load_i    (load),
      .duty_sh_i (duty_sh_q[ch]),
      .cnt_i     (cnt_q),
      .pol_i     (pol_q[ch]),
      .pwm_o     (pwm[ch])
    );
  end

  assign uo_out = 8'(pwm);

endmodule

// File: tb/tb_tqvp_pwm_multi.sv
// Bench for tqvp_pwm_multi: period-phase reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_tqvp_pwm_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit cmp_en = 1'b0;

  tqvp_pwm_multi #(.NUM_CH(4), .PRESC_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference model: position inside the current period, not a counter/direction pair.
  logic       m_en, m_mode, m_wrap;
  logic [3:0] m_presc, m_psc, m_pol;
  logic [7:0] m_top_sh, m_top_act, m_uo;
  logic [7:0] m_duty_sh [4];
  logic [7:0] m_duty_act [4];
  int         m_phase;
  logic [7:0] mc;
  bit         mb, mt;

  function automatic int model_period();
    int t = int'(m_top_act);
    if (t == 0) return 1;
    return m_mode ? 2 * t : t + 1;
  endfunction

  function automatic logic [7:0] model_cnt();
    int t = int'(m_top_act);
    if (t == 0) return 8'h00;
    if (!m_mode || m_phase <= t) return 8'(m_phase);
    return 8'(2 * t - m_phase);
  endfunction

  function automatic bit model_bnd();
    return m_en && (m_psc == m_presc) && (m_phase + 1 == model_period());
  endfunction

  function automatic logic [7:0] model_read(input logic [3:0] a);
    case (a)
      4'h0: return {m_presc, 2'b00, m_mode, m_en};
      4'h1: return m_top_sh;
      4'h2: return {4'h0, m_pol};
      4'h3: return {7'h00, m_wrap};
      4'h4, 4'h5, 4'h6, 4'h7: return m_duty_sh[a - 4'h4];
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_en = 0; m_mode = 0; m_wrap = 0; m_presc = 0; m_psc = 0; m_pol = 0;
      m_top_sh = 8'hFF; m_top_act = 8'hFF; m_uo = 8'h00; m_phase = 0;
      for (int c = 0; c < 4; c++) begin m_duty_sh[c] = 0; m_duty_act[c] = 0; end
    end else begin
      mc = model_cnt();
      mb = model_bnd();
      mt = m_en && (m_psc == m_presc);
      for (int c = 0; c < 4; c++)
        m_uo[c] = m_en ? ((mc < m_duty_act[c]) ^ m_pol[c]) : m_pol[c];
      m_uo[7:4] = 4'h0;
      if (!m_en) begin
        m_psc = 0; m_phase = 0; m_top_act = m_top_sh; m_duty_act = m_duty_sh;
      end else begin
        if (mb) begin m_top_act = m_top_sh; m_duty_act = m_duty_sh; end
        if (data_write && address == 4'h0 && data_in[1] != m_mode) m_phase = 0;
        else if (mt) m_phase = mb ? 0 : m_phase + 1;
        m_psc = mt ? 4'h0 : m_psc + 4'h1;
      end
      if (mb) m_wrap = 1;
      else if (data_write && address == 4'h3 && data_in[0]) m_wrap = 0;
      if (data_write) begin
        case (address)
          4'h0: begin m_en = data_in[0]; m_mode = data_in[1]; m_presc = data_in[7:4]; end
          4'h1: m_top_sh = data_in;
          4'h2: m_pol = data_in[3:0];
          4'h4, 4'h5, 4'h6, 4'h7: m_duty_sh[address - 4'h4] = data_in;
          default: ;
        endcase
      end
    end
  end

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (cmp_en) begin
      check8("uo_out_vs_model", uo_out, m_uo);
      check8("data_out_vs_model", data_out, model_read(address));
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; data_in = d; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_read(input string nm, input logic [3:0] a, input logic [7:0] exp);
    @(negedge clk);
    address = a;
    #1;
    check8(nm, data_out, exp);
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      hi += int'(uo_out[ch]);
      @(negedge clk);
    end
  endtask

  task automatic wait_wrap(output int at);
    at = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      address = 4'h3;
      #1;
      if (data_out[0]) begin at = cyc; break; end
    end
    if (at < 0) begin
      n_chk++; n_err++;
      $display("FAIL wait_wrap: WRAP never set within 200 cycles (cycle %0d)", cyc);
    end
  endtask

  // Returns at the negedge just before a predicted boundary edge.
  task automatic sync_bnd();
    bit found = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (model_bnd()) begin found = 1; break; end
    end
    if (!found) begin
      n_chk++; n_err++;
      $display("FAIL sync_bnd: no boundary within 300 cycles (cycle %0d)", cyc);
    end
  endtask

  int hi, a0, a1;

  initial begin
    rst_n = 1'b0; ui_in = 8'h00; address = 4'h0; data_write = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Reset state
    check8("reset_uo_out", uo_out, 8'h00);
    check_read("reset_ctrl", 4'h0, 8'h00);
    check_read("reset_top", 4'h1, 8'hFF);
    check_read("reset_status", 4'h3, 8'h00);

    // Edge mode TOP=9 DUTY0=3: 3 high per 10-clk period, WRAP every 10 clk
    bus_write(4'h1, 8'd9);
    bus_write(4'h4, 8'd3);
    bus_write(4'h0, 8'h01);
    idle(25);
    count_high(0, 20, hi);
    check_int("edge_ch0_high_20clk", hi, 6);
    bus_write(4'h3, 8'h01);
    wait_wrap(a0);
    bus_write(4'h3, 8'h01);
    wait_wrap(a1);
    check_int("edge_wrap_interval", a1 - a0, 10);

    // Centre mode TOP=4 DUTY1=2: cnt<2 holds at cnt 0,1,1 of the 8-tick cycle
    bus_write(4'h0, 8'h00);
    bus_write(4'h1, 8'd4);
    bus_write(4'h5, 8'd2);
    bus_write(4'h0, 8'h03);
    idle(20);
    count_high(1, 16, hi);
    check_int("centre_ch1_high_16clk", hi, 6);
    bus_write(4'h3, 8'h01);
    wait_wrap(a0);
    bus_write(4'h3, 8'h01);
    wait_wrap(a1);
    check_int("centre_wrap_interval", a1 - a0, 8);

    // Mid-period duty write holds until the boundary
    bus_write(4'h0, 8'h00);
    bus_write(4'h1, 8'd9);
    bus_write(4'h4, 8'd3);
    bus_write(4'h0, 8'h01);
    idle(5);
    sync_bnd();
    idle(2);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin address = 4'h4; data_in = 8'd8; data_write = 1'b1; end
      else data_write = 1'b0;
      hi += int'(uo_out[0]);
      @(negedge clk);
    end
    data_write = 1'b0;
    check_int("duty_old_period", hi, 3);
    count_high(0, 10, hi);
    check_int("duty_new_period", hi, 8);

    // Write on the boundary cycle is deferred one more period
    sync_bnd();
    address = 4'h4; data_in = 8'd2; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
    count_high(0, 20, hi);
    check_int("duty_boundary_write", hi, 8 + 2);

    // Polarity
    bus_write(4'h0, 8'h00);
    bus_write(4'h2, 8'h05);
    idle(2);
    check8("pol_disabled", uo_out, 8'h05);
    bus_write(4'h6, 8'h00);
    bus_write(4'h2, 8'h04);
    bus_write(4'h0, 8'h01);
    idle(3);
    count_high(2, 20, hi);
    check_int("pol_duty0_const_high", hi, 20);
    check_read("pol_readback", 4'h2, 8'h04);

    // PRESC=3, boundary-coincident W1C, mid-period reset
    bus_write(4'h0, 8'h00);
    bus_write(4'h2, 8'h00);
    bus_write(4'h4, 8'd3);
    bus_write(4'h0, 8'h31);
    idle(50);
    count_high(0, 80, hi);
    check_int("presc3_ch0_high_80clk", hi, 24);
    bus_write(4'h3, 8'h01);
    wait_wrap(a0);
    bus_write(4'h3, 8'h01);
    wait_wrap(a1);
    check_int("presc3_wrap_interval", a1 - a0, 40);
    bus_write(4'h3, 8'h01);
    sync_bnd();
    address = 4'h3; data_in = 8'h01; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
    #1;
    check8("w1c_on_boundary", data_out, 8'h01);
    idle(7);
    rst_n = 1'b0;
    @(negedge clk);
    check8("midperiod_reset_uo", uo_out, 8'h00);
    rst_n = 1'b1;
    check_read("midperiod_reset_ctrl", 4'h0, 8'h00);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      data_write = 1'b0;
      rst_n = 1'b1;
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
      end else if (model_bnd() && $urandom_range(0, 3) == 0) begin
        address = 4'h3; data_in = 8'h01; data_write = 1'b1;
      end else if ($urandom_range(0, 5) == 0) begin
        address = 4'($urandom_range(0, 9));
        case (address)
          4'h0: data_in = {2'b00, 2'($urandom_range(0, 3)), 2'b00, 1'($urandom),
                           1'($urandom_range(0, 7) != 0)};
          4'h1: data_in = 8'($urandom_range(0, 8));
          default: data_in = 8'($urandom);
        endcase
        data_write = 1'b1;
      end else begin
        address = 4'($urandom_range(0, 15));
      end
    end
    @(negedge clk);
    data_write = 1'b0;
    rst_n = 1'b1;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
